// File: rtl/vga_mode_display_pkg.sv
// Shared definitions for the VGA mode display: master-state encodings and
// the WIN animation palette, kept as per-channel (R,G,B) enables.
package vga_mode_display_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'b00,
        MODE_PLAY = 2'b01,
        MODE_WIN  = 2'b10,
        MODE_LOSE = 2'b11
    } mode_t;

    // Palette entries as {R,G,B} enables; each enabled channel is driven all-ones.
    localparam logic [2:0] WIN_RGB_RED   = 3'b100;
    localparam logic [2:0] WIN_RGB_GREEN = 3'b010;
    localparam logic [2:0] WIN_RGB_BLUE  = 3'b001;
    localparam logic [2:0] WIN_RGB_WHITE = 3'b111;

    localparam int BORDER_W = 8;

    function automatic logic [2:0] win_rgb(input logic [1:0] idx);
        logic [2:0] rgb;
        case (idx)
            2'd0:    rgb = WIN_RGB_RED;
            2'd1:    rgb = WIN_RGB_GREEN;
            2'd2:    rgb = WIN_RGB_BLUE;
            default: rgb = WIN_RGB_WHITE;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/vga_mode_display_timing_gen.sv
// VGA raster timing: pixel clock-enable divider, H/V counters, visible flag,
// raw active-low syncs and the start-of-vblank frame strobe.
module vga_timing_gen #(
    parameter int PIX_DIV = 4,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int HCNT_W  = $clog2(H_VIS + H_FP + H_SYNC + H_BP),
    parameter int VCNT_W  = $clog2(V_VIS + V_FP + V_SYNC + V_BP)
) (
    input  logic              clk,
    input  logic              srst_n,
    output logic              pix_en,
    output logic [HCNT_W-1:0] hcnt,
    output logic [VCNT_W-1:0] vcnt,
    output logic              visible,
    output logic              hs_raw,
    output logic              vs_raw,
    output logic              frame_strobe
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = $clog2(PIX_DIV);

    logic [DIV_W-1:0]  div_reg;
    logic [HCNT_W-1:0] hcnt_reg;
    logic [VCNT_W-1:0] vcnt_reg;
    logic              h_last;
    logic              v_last;
    int unsigned       h_i;
    int unsigned       v_i;

    assign pix_en = (div_reg == DIV_W'(PIX_DIV - 1));
    assign h_last = (hcnt_reg == HCNT_W'(H_TOT - 1));
    assign v_last = (vcnt_reg == VCNT_W'(V_TOT - 1));

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            div_reg  <= '0;
            hcnt_reg <= '0;
            vcnt_reg <= '0;
        end else begin
            div_reg <= pix_en ? '0 : div_reg + DIV_W'(1);
            if (pix_en) begin
                if (h_last) begin
                    hcnt_reg <= '0;
                    vcnt_reg <= v_last ? '0 : vcnt_reg + VCNT_W'(1);
                end else begin
                    hcnt_reg <= hcnt_reg + HCNT_W'(1);
                end
            end
        end
    end

    // Compare in 32 bits so sync/visible edges equal to 2**W do not wrap.
    assign h_i = 32'(hcnt_reg);
    assign v_i = 32'(vcnt_reg);

    assign hcnt    = hcnt_reg;
    assign vcnt    = vcnt_reg;
    assign visible = (h_i < H_VIS) && (v_i < V_VIS);
    assign hs_raw  = !((h_i >= H_VIS + H_FP) && (h_i < H_VIS + H_FP + H_SYNC));
    assign vs_raw  = !((v_i >= V_VIS + V_FP) && (v_i < V_VIS + V_FP + V_SYNC));

    assign frame_strobe = pix_en && h_last && (vcnt_reg == VCNT_W'(V_VIS - 1));

endmodule

// File: rtl/vga_mode_display.sv
// VGA output stage: frame-synchronous mode latch, WIN palette animation and
// registered colour/sync outputs. Optional PLAY border: VGA_MODE_DISPLAY_BORDER_EN.
module vga_mode_display
    import vga_mode_display_pkg::*;
#(
    parameter int COLOUR_W   = 12,
    parameter int PIX_DIV    = 4,
    parameter int H_VIS      = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VIS      = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int WIN_PERIOD = 8,
    parameter logic [COLOUR_W-1:0] IDLE_COLOUR = 'h00F,
    parameter logic [COLOUR_W-1:0] LOSE_COLOUR = 'hF00
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [1:0]          MASTER_STATE,
    input  logic [COLOUR_W-1:0] COLOUR_IN,
    output logic [9:0]          ADDRH,
    output logic [8:0]          ADDRV,
    output logic [COLOUR_W-1:0] COLOUR_OUT,
    output logic                HS,
    output logic                VS,
    output logic                FRAME_START
);

    localparam int CH_W    = COLOUR_W / 3;
    localparam int HCNT_W  = $clog2(H_VIS + H_FP + H_SYNC + H_BP);
    localparam int VCNT_W  = $clog2(V_VIS + V_FP + V_SYNC + V_BP);
    localparam int FRAME_W = (WIN_PERIOD > 1) ? $clog2(WIN_PERIOD) : 1;

    logic              pix_en;
    logic [HCNT_W-1:0] hcnt;
    logic [VCNT_W-1:0] vcnt;
    logic              visible;
    logic              hs_raw;
    logic              vs_raw;
    logic              frame_strobe;

    vga_timing_gen #(
        .PIX_DIV (PIX_DIV),
        .H_VIS   (H_VIS),
        .H_FP    (H_FP),
        .H_SYNC  (H_SYNC),
        .H_BP    (H_BP),
        .V_VIS   (V_VIS),
        .V_FP    (V_FP),
        .V_SYNC  (V_SYNC),
        .V_BP    (V_BP),
        .HCNT_W  (HCNT_W),
        .VCNT_W  (VCNT_W)
    ) u_timing (
        .clk          (CLK),
        .srst_n       (RESET),
        .pix_en       (pix_en),
        .hcnt         (hcnt),
        .vcnt         (vcnt),
        .visible      (visible),
        .hs_raw       (hs_raw),
        .vs_raw       (vs_raw),
        .frame_strobe (frame_strobe)
    );

    assign ADDRH = visible ? 10'(hcnt) : '0;
    assign ADDRV = visible ? 9'(vcnt)  : '0;

    mode_t                disp_mode_reg;
    logic [FRAME_W-1:0]   frame_cnt_reg;
    logic [1:0]           win_idx_reg;
    logic [2:0]           win_rgb_sel;
    logic [COLOUR_W-1:0]  win_colour;
    logic [COLOUR_W-1:0]  play_colour;
    logic [COLOUR_W-1:0]  colour_next;
    mode_t                master_mode;

    assign master_mode = mode_t'(MASTER_STATE);
    assign win_rgb_sel = win_rgb(win_idx_reg);

    // Channel gi: 0 = B (LSBs), 1 = G, 2 = R (MSBs).
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_win_ch
            assign win_colour[gi*CH_W +: CH_W] = {CH_W{win_rgb_sel[gi]}};
        end
    endgenerate

`ifdef VGA_MODE_DISPLAY_BORDER_EN
    int unsigned h_i;
    int unsigned v_i;
    logic        on_border;

    assign h_i       = 32'(hcnt);
    assign v_i       = 32'(vcnt);
    assign on_border = (h_i < BORDER_W) || (h_i >= H_VIS - BORDER_W) ||
                       (v_i < BORDER_W) || (v_i >= V_VIS - BORDER_W);
    assign play_colour = on_border ? '1 : COLOUR_IN;
`else
    assign play_colour = COLOUR_IN;
`endif

    always_comb begin
        colour_next = '0;
        if (visible) begin
            unique case (disp_mode_reg)
                MODE_IDLE: colour_next = IDLE_COLOUR;
                MODE_PLAY: colour_next = play_colour;
                MODE_WIN:  colour_next = win_colour;
                MODE_LOSE: colour_next = LOSE_COLOUR;
                default:   colour_next = '0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            disp_mode_reg <= MODE_IDLE;
            frame_cnt_reg <= '0;
            win_idx_reg   <= '0;
            COLOUR_OUT    <= '0;
            HS            <= 1'b1;
            VS            <= 1'b1;
            FRAME_START   <= 1'b0;
        end else begin
            FRAME_START <= frame_strobe;
            if (pix_en) begin
                COLOUR_OUT <= colour_next;
                HS         <= hs_raw;
                VS         <= vs_raw;
            end
            if (frame_strobe) begin
                disp_mode_reg <= master_mode;
                // Only consecutive WIN frames advance; any other mode restarts on red.
                if (master_mode != MODE_WIN) begin
                    frame_cnt_reg <= '0;
                    win_idx_reg   <= '0;
                end else if (disp_mode_reg == MODE_WIN) begin
                    if (frame_cnt_reg == FRAME_W'(WIN_PERIOD - 1)) begin
                        frame_cnt_reg <= '0;
                        win_idx_reg   <= win_idx_reg + 2'd1;
                    end else begin
                        frame_cnt_reg <= frame_cnt_reg + FRAME_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_mode_display.sv
// Bench for vga_mode_display on a shrunken raster: pixel-arithmetic reference
// model checked every clock, plus frame-level vectors and directed sequences.
`timescale 1ns/1ps
module tb_vga_mode_display;

    localparam int D      = 3;
    localparam int H_VIS  = 20, H_FP = 2, H_SYNC = 3, H_BP = 3;
    localparam int V_VIS  = 18, V_FP = 2, V_SYNC = 2, V_BP = 2;
    localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int WIN_P  = 2;
    localparam int FRAME_CLKS = H_TOT * V_TOT * D;
    // Output for pixel P appears after edge (P+1)*D counted from reset release.
    localparam int HS_FALL  = (H_VIS + H_FP + 1) * D;
    localparam int HS_LOW   = H_SYNC * D;
    localparam int LINE_CLK = H_TOT * D;
    localparam int VS_FALL  = ((V_VIS + V_FP) * H_TOT + 1) * D;
    localparam int VS_LOW   = V_SYNC * H_TOT * D;
    localparam int PROBE_H  = 10, PROBE_V = 9;
    localparam int PROBE_EDGE = (PROBE_V * H_TOT + PROBE_H + 1) * D;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [1:0]  MASTER_STATE = 2'd0;
    logic [11:0] COLOUR_IN;
    logic [9:0]  ADDRH;
    logic [8:0]  ADDRV;
    logic [11:0] COLOUR_OUT;
    logic        HS, VS, FRAME_START;

    int total = 0;
    int bad   = 0;
    int unsigned cyc = 0;
    int unsigned fs_last = 0;

    always #5 CLK = ~CLK;

    assign COLOUR_IN = {ADDRH[3:0], ADDRV[3:0], 4'h5};

    vga_mode_display #(
        .COLOUR_W(12), .PIX_DIV(D),
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .WIN_PERIOD(WIN_P), .IDLE_COLOUR(12'h00F), .LOSE_COLOUR(12'hF00)
    ) dut (
        .CLK(CLK), .RESET(RESET), .MASTER_STATE(MASTER_STATE), .COLOUR_IN(COLOUR_IN),
        .ADDRH(ADDRH), .ADDRV(ADDRV), .COLOUR_OUT(COLOUR_OUT),
        .HS(HS), .VS(VS), .FRAME_START(FRAME_START)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [11:0] model_colour(input int mode, input int win_frames,
                                                 input int h, input int v);
        logic [11:0] pal [4];
        pal[0] = 12'hF00; pal[1] = 12'h0F0; pal[2] = 12'h00F; pal[3] = 12'hFFF;
        if (!(h < H_VIS && v < V_VIS)) return 12'h000;
        case (mode)
            0: return 12'h00F;
            1: begin
`ifdef VGA_MODE_DISPLAY_BORDER_EN
                if (h < 8 || h >= H_VIS - 8 || v < 8 || v >= V_VIS - 8) return 12'hFFF;
`endif
                return {4'(h), 4'(v), 4'h5};
            end
            2: return pal[(win_frames / WIN_P) % 4];
            default: return 12'hF00;
        endcase
    endfunction

    int unsigned k = 0;
    int m_mode = 0, win_frames = 0;
    logic [11:0] e_col = '0;
    logic e_hs = 1'b1, e_vs = 1'b1, e_fs = 1'b0;
    bit model_ok = 1'b0;

    always begin : model_check
        logic r_s;
        logic [1:0] ms_s;
        int p, h, v, q, hq, vq;
        @(posedge CLK);
        r_s  = RESET;
        ms_s = MASTER_STATE;
        #1;
        if (!r_s) begin
            k = 0; m_mode = 0; win_frames = 0;
            e_col = '0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            e_fs = 1'b0;
            if (k % D == D - 1) begin
                p = int'(k / D); h = p % H_TOT; v = (p / H_TOT) % V_TOT;
                e_col = model_colour(m_mode, win_frames, h, v);
                e_hs  = !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC);
                e_vs  = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC);
                if (h == H_TOT - 1 && v == V_VIS - 1) begin
                    win_frames = (ms_s == 2'd2 && m_mode == 2) ? win_frames + 1 : 0;
                    m_mode = int'(ms_s);
                    e_fs = 1'b1;
                end
            end
            k++;
        end
        if (model_ok) begin
            q = int'(k / D); hq = q % H_TOT; vq = (q / H_TOT) % V_TOT;
            check("colour_out", 32'(COLOUR_OUT), 32'(e_col));
            check("hs", 32'(HS), 32'(e_hs));
            check("vs", 32'(VS), 32'(e_vs));
            check("frame_start", 32'(FRAME_START), 32'(e_fs));
            check("addrh", 32'(ADDRH), (hq < H_VIS && vq < V_VIS) ? 32'(hq) : 32'd0);
            check("addrv", 32'(ADDRV), (hq < H_VIS && vq < V_VIS) ? 32'(vq) : 32'd0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic wait_fs(output int unsigned intv);
        int n = 0;
        do begin tick(); n++; end while (FRAME_START !== 1'b1 && n < 3000);
        if (FRAME_START !== 1'b1) begin
            total++; bad++;
            $display("FAIL wait_frame_start timeout actual=0 expected=1 at t=%0t", $time);
        end
        intv = cyc - fs_last;
        fs_last = cyc;
    endtask

    task automatic wait_pixel(input int hh, input int vv);
        int n = 0;
        while (!(ADDRH == 10'(hh) && ADDRV == 9'(vv)) && n < 3000) begin tick(); n++; end
        if (!(ADDRH == 10'(hh) && ADDRV == 9'(vv))) begin
            total++; bad++;
            $display("FAIL wait_pixel timeout actual=(%0d,%0d) expected=(%0d,%0d)", ADDRH, ADDRV, hh, vv);
        end
    endtask

    // Counts edges from reset release and checks sync placement and the IDLE fill.
    task automatic timing_check(input string tag);
        int n = 0, hs_f1 = -1, hs_r1 = -1, hs_f2 = -1, vs_f = -1, vs_r = -1;
        logic ph = 1'b1, pv = 1'b1;
        while (n < VS_FALL + VS_LOW + 50) begin
            tick(); n++;
            if (ph && !HS) begin if (hs_f1 < 0) hs_f1 = n; else if (hs_f2 < 0) hs_f2 = n; end
            if (!ph && HS && hs_r1 < 0) hs_r1 = n;
            if (pv && !VS && vs_f < 0) vs_f = n;
            if (!pv && VS && vs_r < 0) vs_r = n;
            if (n == PROBE_EDGE) check({tag, "_idle_fill"}, 32'(COLOUR_OUT), 32'h00F);
            ph = HS; pv = VS;
        end
        check({tag, "_hs_first_fall"}, hs_f1, HS_FALL);
        check({tag, "_hs_low_len"}, hs_r1 - hs_f1, HS_LOW);
        check({tag, "_line_period"}, hs_f2 - hs_f1, LINE_CLK);
        check({tag, "_vs_first_fall"}, vs_f, VS_FALL);
        check({tag, "_vs_low_len"}, vs_r - vs_f, VS_LOW);
        $display("timing %s: hs_fall=%0d vs_fall=%0d", tag, hs_f1, vs_f);
    endtask

    typedef struct {
        logic [1:0]  ms;
        logic [11:0] exp;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    initial begin : stimulus
        int unsigned intv;
        vecs[0]  = '{2'd0, 12'h00F};  vecs[1]  = '{2'd1, 12'hA95};
        vecs[2]  = '{2'd2, 12'hF00};  vecs[3]  = '{2'd2, 12'hF00};
        vecs[4]  = '{2'd2, 12'h0F0};  vecs[5]  = '{2'd2, 12'h0F0};
        vecs[6]  = '{2'd2, 12'h00F};  vecs[7]  = '{2'd2, 12'h00F};
        vecs[8]  = '{2'd2, 12'hFFF};  vecs[9]  = '{2'd2, 12'hFFF};
        vecs[10] = '{2'd2, 12'hF00};  vecs[11] = '{2'd3, 12'hF00};
        vecs[12] = '{2'd2, 12'hF00};  vecs[13] = '{2'd1, 12'hA95};

        RESET = 1'b0; MASTER_STATE = 2'd0;
        repeat (3) tick();
        RESET = 1'b1;
        timing_check("release");

        // One vector per frame: the mode set after a vblank shows in the next frame.
        wait_fs(intv);
        MASTER_STATE = vecs[0].ms;
        for (int i = 1; i <= NV; i++) begin
            wait_fs(intv);
            check("frame_period", intv, FRAME_CLKS);
            MASTER_STATE = (i < NV) ? vecs[i].ms : 2'd0;
            wait_pixel(PROBE_H + 1, PROBE_V);
            check("vec_probe_colour", 32'(COLOUR_OUT), 32'(vecs[i-1].exp));
            $display("vec %0d ms=%0d colour=%03h expect=%03h", i - 1, vecs[i-1].ms,
                     COLOUR_OUT, vecs[i-1].exp);
        end

        // Rapid LOSE/WIN toggling within a frame: only the value at the latch counts.
        wait_fs(intv);
        MASTER_STATE = 2'd3; repeat (500) tick();
        MASTER_STATE = 2'd2; repeat (500) tick();
        MASTER_STATE = 2'd3; repeat (500) tick();
        MASTER_STATE = 2'd2;
        wait_fs(intv);
        wait_pixel(PROBE_H + 1, PROBE_V);
        check("glitch_win_restart", 32'(COLOUR_OUT), 32'hF00);
        $display("glitch: colour=%03h", COLOUR_OUT);

        // Random mode changes at arbitrary times; the model checks every clock.
        repeat (12000) begin
            tick();
            if ($urandom_range(0, 399) == 0) MASTER_STATE = 2'($urandom_range(0, 3));
        end

        // One-cycle reset mid-frame.
        MASTER_STATE = 2'd1;
        wait_pixel(12, 7);
        RESET = 1'b0;
        tick();
        check("rst_colour", 32'(COLOUR_OUT), 32'h0);
        check("rst_hs", 32'(HS), 32'h1);
        check("rst_vs", 32'(VS), 32'h1);
        check("rst_addrh", 32'(ADDRH), 32'h0);
        check("rst_addrv", 32'(ADDRV), 32'h0);
        check("rst_frame_start", 32'(FRAME_START), 32'h0);
        $display("mid-frame reset applied at t=%0t", $time);
        RESET = 1'b1;
        timing_check("rerelease");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #950000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_mode_display.md
Name: vga_mode_display

Overview:
- Parametrised successor to the snake game's display state machine.
- Owns VGA pixel timing: a clock-enable divider plus H/V counters with generics for resolution and porches.
- Selects pixel colour by master game state: IDLE solid, PLAY passthrough, WIN animated, LOSE solid.
- Latches the mode only at frame boundaries, so a mode change never tears mid-frame.
- Sits between the master FSM, the game pixel source and the VGA pins.

Parameters:
- COLOUR_W, 12, colour bus width; must be a multiple of 3 (R,G,B channels of COLOUR_W/3 bits, R in MSBs).
- PIX_DIV, 4, CLK cycles per pixel; ≥2.
- H_VIS, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, horizontal sync width.
- H_BP, 48, horizontal back porch.
- V_VIS, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vertical sync width.
- V_BP, 33, vertical back porch.
- WIN_PERIOD, 8, frames per WIN palette step; ≥1.
- IDLE_COLOUR, 'h00F, IDLE fill colour (COLOUR_W bits).
- LOSE_COLOUR, 'hF00, LOSE fill colour (COLOUR_W bits).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-low reset.
- MASTER_STATE  in  2  00 IDLE, 01 PLAY, 10 WIN, 11 LOSE.
- COLOUR_IN  in  COLOUR_W  game pixel for the current ADDRH/ADDRV.
- ADDRH  out  10  current horizontal pixel coordinate.
- ADDRV  out  9  current vertical line coordinate.
- COLOUR_OUT  out  COLOUR_W  registered pixel to DAC.
- HS  out  1  horizontal sync, active low.
- VS  out  1  vertical sync, active low.
- FRAME_START  out  1  one-CLK pulse when the display mode is latched.

Behaviour:
- Reset (RESET=0 at a CLK edge; wins over all other events):
  - div, hcnt, vcnt, frame counter and WIN index clear to 0.
  - disp_mode = IDLE.
  - COLOUR_OUT = 0, HS = 1, VS = 1, FRAME_START = 0.
  - Applies mid-frame with no draining; timing restarts at (0,0) on the first CLK after release.
- Pixel enable:
  - div counts 0..PIX_DIV-1; pix_en = (div == PIX_DIV-1).
  - hcnt/vcnt and all registered outputs change only on pix_en cycles.
- Counters:
  - H_TOT = H_VIS+H_FP+H_SYNC+H_BP; V_TOT likewise.
  - hcnt wraps H_TOT-1→0; vcnt increments on the hcnt wrap and wraps V_TOT-1→0.
- Addresses:
  - ADDRH = hcnt and ADDRV = vcnt (truncated) while visible; otherwise ADDRH = 0, ADDRV = 0.
  - COLOUR_IN is sampled on the pix_en cycle, so the source has PIX_DIV-1 CLKs to respond.
- Sync (registered):
  - HS = 0 iff H_VIS+H_FP ≤ hcnt < H_VIS+H_FP+H_SYNC.
  - VS uses the same rule on vcnt.
  - Latency: COLOUR_OUT, HS and VS all lag the counters by exactly one pixel and stay mutually aligned.
- Mode latch:
  - On the pix_en where hcnt wraps to 0 and vcnt becomes V_VIS (start of vblank), disp_mode ← MASTER_STATE and FRAME_START pulses.
  - MASTER_STATE changes at any other time have no visible effect until that point.
- Colour (visible region only; blanking forces COLOUR_OUT = 0):
  - IDLE → IDLE_COLOUR.
  - PLAY → COLOUR_IN.
  - WIN → palette[win_idx], cycling red, green, blue, white (each channel all-ones or zero).
  - LOSE → LOSE_COLOUR.
- WIN animation:
  - The frame counter advances on each FRAME_START while disp_mode == WIN.
  - At WIN_PERIOD-1 the counter wraps to 0 and win_idx increments mod 4.
  - Leaving WIN clears the frame counter and win_idx, so re-entry always starts on red.
- Widths: counters are sized with clog2 of H_TOT/V_TOT; there is no overflow by construction.

Optional Feature:
- Macro: VGA_MODE_DISPLAY_BORDER_EN.
- Defined: in PLAY only, visible pixels with hcnt < 8, hcnt ≥ H_VIS-8, vcnt < 8 or vcnt ≥ V_VIS-8 output all-ones (white) instead of COLOUR_IN.
- Undefined: PLAY is pure passthrough and no border logic is synthesised.

Decomposition:
- Shared package holds the mode encodings (IDLE/PLAY/WIN/LOSE) and the 4-entry WIN palette constants.
- Natural sub-module: vga_timing_gen, covering the divider, H/V counters, visible flag, raw sync and the frame-boundary strobe.
- The top level handles the mode latch, WIN animation and colour mux/output register.

Test Plan:
- Reset release, PIX_DIV=4, defaults:
  - First HS low exactly 656 pixels after release, lasting 96 pixels.
  - Line period 800 pixels = 3200 CLKs.
  - VS low at lines 490–491; frame period 525 lines.
- MASTER_STATE switched IDLE→PLAY mid-visible-line 100 → COLOUR_OUT stays 'h00F until vblank; from the next frame's line 0 it equals COLOUR_IN driven as {ADDRH[3:0],ADDRV[3:0],4'h5}, delayed one pixel.
- WIN held with WIN_PERIOD=2 → palette visible as F00, F00, 0F0, 0F0, 00F, 00F, FFF, FFF, F00 over successive frames; blanking always 0.
- LOSE → WIN → LOSE → WIN within one frame → only the value present at the vblank latch takes effect; the WIN sequence restarts at F00.
- RESET asserted for 1 CLK at hcnt=300, vcnt=200 → next CLK: COLOUR_OUT=0, HS=VS=1, ADDRH=ADDRV=0, mode IDLE; timing then repeats the first scenario.
- With VGA_MODE_DISPLAY_BORDER_EN in PLAY, COLOUR_IN=0 → pixels (0,0), (639,479) and (7,240) are 'hFFF; pixel (8,8) is 0.
